// File: rtl/sweep_ctrl.sv
// -----------------------------------------------------------------------------
// sweep_ctrl
//
// Frequency-sweep sequencer for the FIR_LPF test-tone generator. It drives the
// s_clk / en / f_set inputs of the 12-bit ROM address generator. A divided
// sample strobe (s_clk, period DIV, 50 % duty) runs while a sweep is active.
// The tone frequency word steps from f_start to f_stop (inclusive) by f_step.
// Each frequency is held for max(dwell,1) sample periods.
//
// Parameters
//   DIV     clk cycles per sample period (even, >= 4)
//   DW      width of the dwell count
//
// Ports
//   clk      in   system clock (shared with the address generator)
//   rst      in   asynchronous reset, active-low
//   start    in   one-cycle launch pulse, honoured only in IDLE
//   abort    in   stop immediately, highest priority
//   cont     in   0 = single sweep, 1 = wrap to f_start and repeat
//   f_start  in   first frequency word
//   f_stop   in   last frequency word (inclusive)
//   f_step   in   increment per step (0 = hold f_start until abort)
//   dwell    in   sample periods per frequency (0 behaves as 1)
//   s_clk    out  sample strobe
//   en       out  enable to the address generator
//   f_set    out  current frequency word
//   busy     out  high while a sweep is running
//   done     out  one-cycle pulse when a single sweep completes normally
//
// All outputs come straight from flops; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module sweep_ctrl #(
  parameter int DIV = 50,
  parameter int DW  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          cont,
  input  logic [19:0]   f_start,
  input  logic [19:0]   f_stop,
  input  logic [19:0]   f_step,
  input  logic [DW-1:0] dwell,
  output logic          s_clk,
  output logic          en,
  output logic [19:0]   f_set,
  output logic          busy,
  output logic          done
);

  localparam int DCW = $clog2(DIV);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [DCW-1:0] DIV_HALF = DCW'(DIV / 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [DCW-1:0]  r_div_cnt;
  logic [DCW-1:0]  w_div_nxt;
  logic [DW-1:0]   r_dwl_cnt;
  logic [DW-1:0]   w_dwl_nxt;
  logic [19:0]     r_f_set;
  logic [19:0]     w_f_set_nxt;
  logic            r_s_clk;
  logic            w_s_clk_nxt;
  logic            r_en;
  logic            w_en_nxt;
  logic            r_busy;
  logic            w_busy_nxt;
  logic            r_done;
  logic            w_done_nxt;

  // Shadow copies of the sweep settings, frozen at launch.
  logic [19:0]     r_sh_start;
  logic [19:0]     r_sh_stop;
  logic [19:0]     r_sh_step;
  logic [DW-1:0]   r_sh_dwm1;
  logic            r_sh_cont;

  logic            w_launch;
  logic [DW-1:0]   w_dwell_m1;
  logic            w_period_end;
  logic            w_dwell_end;
  logic [20:0]     w_nxt;

  assign w_launch     = (r_state == ST_IDLE) && start && !abort;
  // dwell of 0 is treated as 1, so the terminal dwell count is 0 in both cases.
  assign w_dwell_m1   = (dwell == '0) ? '0 : dwell - DW'(1);
  assign w_period_end = (r_div_cnt == DIV_LAST);
  assign w_dwell_end  = (r_dwl_cnt == r_sh_dwm1);
  // One extra bit keeps the carry so a wrap past 0xFFFFF ends the sweep
  // instead of restarting low.
  assign w_nxt        = {1'b0, r_f_set} + {1'b0, r_sh_step};

  // Settings only matter from launch onward, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_launch) begin
      r_sh_start <= f_start;
      r_sh_stop  <= f_stop;
      r_sh_step  <= f_step;
      r_sh_dwm1  <= w_dwell_m1;
      r_sh_cont  <= cont;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_div_cnt <= '0;
      r_dwl_cnt <= '0;
      r_f_set   <= '0;
      r_s_clk   <= 1'b0;
      r_en      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div_cnt <= w_div_nxt;
      r_dwl_cnt <= w_dwl_nxt;
      r_f_set   <= w_f_set_nxt;
      r_s_clk   <= w_s_clk_nxt;
      r_en      <= w_en_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div_cnt;
    w_dwl_nxt   = r_dwl_cnt;
    w_f_set_nxt = r_f_set;
    w_s_clk_nxt = 1'b0;
    w_en_nxt    = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    if (abort) begin
      // Abort wins over everything, including a same-cycle start; f_set holds.
      w_state_nxt = ST_IDLE;
      w_div_nxt   = '0;
      w_dwl_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_nxt = ST_RUN;
            w_div_nxt   = '0;
            w_dwl_nxt   = '0;
            w_f_set_nxt = f_start;
            w_en_nxt    = 1'b1;
            w_busy_nxt  = 1'b1;
          end
        end

        ST_RUN: begin
          w_en_nxt   = 1'b1;
          w_busy_nxt = 1'b1;
          w_div_nxt  = w_period_end ? '0 : r_div_cnt + DCW'(1);
          if (w_period_end) begin
            if (w_dwell_end) begin
              w_dwl_nxt = '0;
              if (r_sh_step == '0) begin
                w_f_set_nxt = r_f_set;
              end else if (w_nxt <= {1'b0, r_sh_stop}) begin
                w_f_set_nxt = w_nxt[19:0];
              end else if (r_sh_cont) begin
                w_f_set_nxt = r_sh_start;
              end else begin
                // Sweep finished: en/busy/s_clk drop together with done rising.
                w_state_nxt = ST_DONE;
                w_en_nxt    = 1'b0;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_div_nxt   = '0;
              end
            end else begin
              w_dwl_nxt = r_dwl_cnt + DW'(1);
            end
          end
        end

        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    // s_clk is registered from the counter value it will accompany, so the
    // strobe lines up with div_cnt (high for the first half of each period).
    if (w_busy_nxt) begin
      w_s_clk_nxt = (w_div_nxt < DIV_HALF);
    end
  end

  assign s_clk = r_s_clk;
  assign en    = r_en;
  assign f_set = r_f_set;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_sweep_ctrl.sv
module tb_sweep_ctrl;

  localparam int DIV = 4;
  localparam int DW  = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic          cont;
  logic [19:0]   f_start;
  logic [19:0]   f_stop;
  logic [19:0]   f_step;
  logic [DW-1:0] dwell;
  logic          s_clk;
  logic          en;
  logic [19:0]   f_set;
  logic          busy;
  logic          done;

  sweep_ctrl #(.DIV(DIV), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .cont    (cont),
    .f_start (f_start),
    .f_stop  (f_stop),
    .f_step  (f_step),
    .dwell   (dwell),
    .s_clk   (s_clk),
    .en      (en),
    .f_set   (f_set),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record layout: {done, busy, en, s_clk, f_set}
  logic [23:0] q[$];
  int total = 0;
  int bad   = 0;
  int n_busy = 0;
  int n_rise = 0;
  int n_done = 0;
  logic prev_s = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected record for every cycle the DUT shows activity.
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (busy || done) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got busy=%0b done=%0b f_set=0x%0h with nothing expected at %0t",
                     busy, done, f_set, $time);
          end else begin
            e = q.pop_front();
            chk("trace", {8'h0, done, busy, en, s_clk, f_set}, {8'h0, e});
          end
        end
        if (busy) n_busy++;
        if (done) n_done++;
        if (s_clk && !prev_s) n_rise++;
        prev_s = s_clk;
      end else begin
        prev_s = 1'b0;
      end
    end
  end

  // Cycle-by-cycle reference of one sweep, capped at maxcyc busy cycles.
  task automatic push_model(input logic [19:0] fs, input logic [19:0] fe, input logic [19:0] st,
                            input logic [15:0] dw, input logic ct, input int maxcyc);
    logic [19:0] f;
    logic [20:0] nx;
    int d;
    int n;
    logic fin;
    f = fs;
    d = (dw == 0) ? 1 : int'(dw);
    n = 0;
    fin = 1'b0;
    while (!fin) begin
      for (int c = 0; c < DIV * d && n < maxcyc; c++) begin
        q.push_back({1'b0, 1'b1, 1'b1, ((c % DIV) < DIV / 2) ? 1'b1 : 1'b0, f});
        n++;
      end
      if (n >= maxcyc) begin
        fin = 1'b1;
      end else begin
        nx = {1'b0, f} + {1'b0, st};
        if (st == 20'd0) begin
          f = f;
        end else if (nx <= {1'b0, fe}) begin
          f = nx[19:0];
        end else if (ct) begin
          f = fs;
        end else begin
          q.push_back({1'b1, 1'b0, 1'b0, 1'b0, f});
          fin = 1'b1;
        end
      end
    end
  endtask

  task automatic set_in(input logic [19:0] a, input logic [19:0] b, input logic [19:0] c,
                        input logic [15:0] d, input logic ct);
    f_start = a;
    f_stop  = b;
    f_step  = c;
    dwell   = d;
    cont    = ct;
  endtask

  // Returns at the negedge of the first busy cycle (t1).
  task automatic launch();
    @(negedge clk);
    n_busy = 0;
    n_rise = 0;
    n_done = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_single(input string name, input logic [19:0] a, input logic [19:0] b,
                            input logic [19:0] c, input logic [15:0] d,
                            input int exp_busy, input int exp_rise, input logic [19:0] exp_last);
    set_in(a, b, c, d, 1'b0);
    push_model(a, b, c, d, 1'b0, 1000);
    launch();
    repeat (exp_busy + 3) @(negedge clk);
    chk({name, "_qempty"}, q.size(), 0);
    chk({name, "_busy_cycles"}, n_busy, exp_busy);
    chk({name, "_rises"}, n_rise, exp_rise);
    chk({name, "_done_count"}, n_done, 1);
    chk({name, "_last_fset"}, {12'h0, f_set}, {12'h0, exp_last});
  endtask

  task automatic run_abort(input string name, input logic [19:0] a, input logic [19:0] b,
                           input logic [19:0] c, input logic [15:0] d, input logic ct,
                           input int k, input logic [19:0] exp_hold);
    set_in(a, b, c, d, ct);
    push_model(a, b, c, d, ct, k);
    launch();
    repeat (k - 1) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk({name, "_busy_after_abort"}, {31'h0, busy}, 0);
    chk({name, "_en_after_abort"}, {31'h0, en}, 0);
    chk({name, "_fset_hold"}, {12'h0, f_set}, {12'h0, exp_hold});
    repeat (3) @(negedge clk);
    chk({name, "_qempty"}, q.size(), 0);
    chk({name, "_busy_cycles"}, n_busy, k);
    chk({name, "_no_done"}, n_done, 0);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    set_in(20'd0, 20'd0, 20'd0, 16'd0, 1'b0);
    #7;
    chk("reset_outputs", {8'h0, done, busy, en, s_clk, f_set}, 32'h0);
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_outputs", {8'h0, done, busy, en, s_clk, f_set}, 32'h0);

    // Basic sweep: 100..300 step 100, dwell 2 -> 24 busy cycles, 6 rises.
    run_single("basic", 20'd100, 20'd300, 20'd100, 16'd2, 24, 6, 20'd300);

    // 21-bit sum overflows past f_stop: one dwell at 0xFFFF0.
    run_single("ovf", 20'hFFFF0, 20'hFFFFF, 20'h00020, 16'd2, 8, 2, 20'hFFFF0);

    // dwell = 0 behaves as 1: three frequencies of DIV cycles each.
    run_single("dwell0", 20'd100, 20'd300, 20'd100, 16'd0, 12, 3, 20'd100 + 20'd200);

    // f_start > f_stop: single dwell at f_start.
    run_single("inverted", 20'd500, 20'd100, 20'd1, 16'd1, 4, 1, 20'd500);

    // Continuous: 100,200,300,100,... abort after 60 cycles (8th frequency = 200).
    run_abort("cont", 20'd100, 20'd300, 20'd100, 16'd2, 1'b1, 60, 20'd200);

    // f_step = 0 holds f_start until abort.
    run_abort("step0", 20'd77, 20'd300, 20'd0, 16'd2, 1'b0, 40, 20'd77);

    // Abort in the same cycle as start in IDLE: nothing launches.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_over_start", {31'h0, busy}, 0);

    // Start pulses during RUN and in the DONE cycle, plus input changes, are ignored.
    set_in(20'd100, 20'd300, 20'd100, 16'd2, 1'b0);
    push_model(20'd100, 20'd300, 20'd100, 16'd2, 1'b0, 1000);
    launch();
    for (int i = 2; i <= 26; i++) begin
      @(negedge clk);
      start = (i == 5 || i == 25);
      if (i == 6) set_in(20'd7, 20'd9, 20'd1, 16'd0, 1'b1);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("ignore_qempty", q.size(), 0);
    chk("ignore_busy_cycles", n_busy, 24);
    chk("ignore_done_count", n_done, 1);
    chk("ignore_last_fset", {12'h0, f_set}, 32'd300);
    chk("ignore_idle", {31'h0, busy}, 0);

    // Asynchronous reset mid-sweep, then a clean restart.
    set_in(20'd100, 20'd300, 20'd100, 16'd2, 1'b0);
    push_model(20'd100, 20'd300, 20'd100, 16'd2, 1'b0, 1000);
    launch();
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_outputs", {8'h0, done, busy, en, s_clk, f_set}, 32'h0);
    q.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    run_single("after_rst", 20'd100, 20'd300, 20'd100, 16'd2, 24, 6, 20'd300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sweep_ctrl.md
# sweep_ctrl

Frequency-sweep sequencer for the FIR_LPF test-tone generator. It sits directly upstream of the 12-bit ROM address generator and drives that generator's `s_clk`, `en` and `f_set` inputs. It produces a divided sample strobe and steps the tone frequency from a start value to a stop value in fixed increments, holding each frequency for a programmable number of samples. Software or a top-level FSM launches a sweep with a one-cycle `start` pulse and learns of completion from `busy` and `done`.

## Interface
- `DIV`, default 50: `clk` cycles per sample period; must be even and at least 4.
- `DW`, default 16: width of the dwell count.
- `clk`  in  1  system clock; same clock as the address generator.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle launch pulse; sampled only in IDLE.
- `abort`  in  1  stops any sweep immediately; highest priority.
- `cont`  in  1  0 = single sweep; 1 = wrap to `f_start` and repeat until abort.
- `f_start`  in  20  first frequency word.
- `f_stop`  in  20  last frequency word, inclusive.
- `f_step`  in  20  increment per step; 0 = hold `f_start` until abort.
- `dwell`  in  DW  sample periods per frequency; 0 is treated as 1.
- `s_clk`  out  1  sample strobe, square wave of period DIV with 50 % duty.
- `en`  out  1  enable to the address generator.
- `f_set`  out  20  current frequency word.
- `busy`  out  1  high while a sweep is running.
- `done`  out  1  one-cycle pulse when a single sweep completes normally.

## Operation
- **States:**
  - IDLE: `s_clk`=0, `en`=0, `busy`=0.
  - RUN.
  - DONE: one cycle; `done`=1, then returns to IDLE.
- **Reset values:** every output 0, state IDLE, all counters 0.
- **Launch (IDLE, `start`=1, `abort`=0):**
  - Latch `f_start`, `f_stop`, `f_step`, `dwell` and `cont` into shadow registers. Input changes during RUN have no effect.
  - Load `f_set`=`f_start`, clear the divider and the dwell counter, enter RUN.
- **Divider in RUN:**
  - `div_cnt` counts 0..DIV-1 and wraps.
  - `s_clk`=1 while `div_cnt` < DIV/2, else 0.
  - The first RUN cycle has `div_cnt`=0, so `s_clk` rises in the same cycle `busy` rises.
- **Dwell:** `dwl_cnt` increments on each cycle with `div_cnt`=DIV-1, i.e. the end of a sample period.
- **Step event:** occurs when `div_cnt`=DIV-1 and `dwl_cnt`=max(dwell,1)-1.
  - `dwl_cnt` clears.
  - `nxt` = `f_set` + `f_step`, computed 21 bits wide.
  - If `f_step`=0: no change to `f_set`; continue.
  - Else if `nxt` ≤ `f_stop` (21-bit compare, carry included): `f_set` ← `nxt[19:0]`.
  - Else if `cont`=1: `f_set` ← `f_start`; continue.
  - Else: go to DONE and drop `en`, `busy` and `s_clk` in that cycle. `f_set` keeps its last value.
- **`f_start` > `f_stop`:** one dwell at `f_start`, then end (or wrap in continuous mode).
- **`abort`:** in any state, the next cycle is IDLE with `en`=`busy`=`s_clk`=0 and no `done`. Abort overrides `start` in the same cycle. `f_set` holds its value.
- **`start` while busy:** ignored. **`start` in the DONE cycle:** ignored.

## Timing
- Start pulse in cycle t0; `busy`, `en` and `s_clk` go to 1 and `f_set`=`f_start` in cycle t0+1.
- Each frequency is presented for exactly DIV·max(dwell,1) cycles.
- `f_set` changes in the cycle after the last low cycle of a period, coincident with the next rising edge of `s_clk`. The address generator samples `s_clk` through two flops, so the new word is stable before that generator detects the edge.
- Single sweep with N frequencies: `busy` is high for exactly N·DIV·max(dwell,1) cycles; `done` is asserted in the first cycle after `busy` falls.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Basic sweep.** DIV=4, `f_start`=100, `f_stop`=300, `f_step`=100, `dwell`=2, `cont`=0; start at t0.
  - `f_set` = 100 for t1–t8, 200 for t9–t16, 300 for t17–t24.
  - `busy` is high for 24 cycles; `done`=1 at t25.
  - 6 rising edges of `s_clk` in total.
- **Overflow and end.** `f_start`=0xFFFF0, `f_step`=0x20, `f_stop`=0xFFFFF.
  - The 21-bit sum exceeds `f_stop`, so the sweep ends after one dwell; `f_set` stays 0xFFFF0.
- **Continuous mode.** Same settings as the basic sweep with `cont`=1.
  - `f_set` sequence is 100, 200, 300, 100, ...
  - `done` never asserts; `abort` at any cycle gives `busy`=0 the next cycle and no `done`.
- **Degenerate inputs.**
  - `dwell`=0: each frequency lasts DIV cycles.
  - `f_step`=0: `f_set` holds `f_start` indefinitely until `abort`.
  - `f_start`=500, `f_stop`=100, `f_step`=1: one dwell, then `done`.
- **Start and reset corner cases.**
  - `start` pulses during RUN and in the DONE cycle are ignored.
  - Changing the `f_*` inputs during RUN does not alter the sequence.
  - Asserting `rst` low mid-sweep zeroes every output immediately and asynchronously.
  - After `rst` returns high, a new `start` runs correctly.
